sha_msg_padder: RTL and testbench

Front end of the SHA-256 hashing path: accepts a message as a big-endian 32-bit word stream and performs FIPS 180-4 padding (0x80 marker, zero fill, 64-bit bit-length). It emits complete 512-bit blocks as one-cycle strobes that connect directly to `sha_core` `in_valid`/`message`. Blocks of one message are issued exactly BLOCK_GAP cycles apart, which is the chaining cadence the core requires.

---
 rtl/sha_pkg.sv | 21 ++
 rtl/sha_pad_word.sv | 38 +++
 rtl/sha_msg_padder.sv | 235 +++++++++++++++++++++++
 tb/tb_sha_msg_padder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 message padder.
//   state_t     : padder FSM states
//   BLOCK_WORDS : 32-bit words per 512-bit block
//   PAD_BYTE    : marker byte appended after the message
//   LEN_WORD_HI : block word index holding the upper 32 length bits
package sha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PAD,
        ST_LEN,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    localparam int         BLOCK_WORDS = 16;
    localparam logic [7:0] PAD_BYTE    = 8'h80;
    localparam int         LEN_WORD_HI = 14;

endpackage

// File: rtl/sha_pad_word.sv
// Combinational byte merge for one 32-bit block word.
//   cur_word : current buffer word; bytes before offset are kept
//   in_data  : incoming word, first byte in [31:24]
//   in_bytes : number of in_data bytes to place (0..4)
//   offset   : byte position inside the word where in_data starts
//   mark     : place the padding marker right after the placed bytes
//   word_out : merged word; every byte past the data/marker is zero
module sha_pad_word
    import sha_pkg::*;
(
    input  logic [31:0] cur_word,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_bytes,
    input  logic [1:0]  offset,
    input  logic        mark,
    output logic [31:0] word_out
);

    logic [31:0] shifted;
    logic [3:0]  end_pos;

    always_comb begin
        // Align in_data so its byte 0 lands on byte lane 'offset'.
        shifted  = in_data >> {offset, 3'b000};
        end_pos  = {2'b00, offset} + {1'b0, in_bytes};
        word_out = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(offset)) begin
                word_out[31-8*i -: 8] = cur_word[31-8*i -: 8];
            end else if (i < int'(end_pos)) begin
                word_out[31-8*i -: 8] = shifted[31-8*i -: 8];
            end else if (mark && (i == int'(end_pos))) begin
                word_out[31-8*i -: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: packs a big-endian word stream into 512-bit
// blocks, appends the 0x80 marker, zero fill and 64-bit bit length, and
// strobes finished blocks spaced BLOCK_GAP cycles apart.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : word handshake
//   in_data/in_bytes    : message word (left-justified) and valid byte count
//   in_last             : final word of the message
//   out_valid           : one-cycle block strobe
//   out_first/out_last  : block position within its message
//   message             : block, word 0 in [511:480], held until next strobe
//   err_underrun        : continuation block missed its slot
module sha_msg_padder
    import sha_pkg::*;
#(
    parameter int BLOCK_GAP = 64,
    parameter int LEN_W     = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic [2:0]   in_bytes,
    input  logic         in_last,
    output logic         out_valid,
    output logic         out_first,
    output logic         out_last,
    output logic [511:0] message,
    output logic         err_underrun
);

    localparam int GAP_W = $clog2(BLOCK_GAP + 1);
    typedef logic [0:BLOCK_WORDS-1][31:0] blk_t;

    state_t           state_q, state_d;
    blk_t             blk_q, blk_d, len_blk, issue_blk;
    logic [6:0]       bp_q, bp_d, bp_nxt;
    logic [LEN_W-1:0] len_q, len_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [511:0]     msg_q, msg_d;
    logic             out_valid_q, out_valid_d, out_first_q, out_first_d;
    logic             out_last_q, out_last_d, err_q, err_d;
    logic             first_q, first_d, last_q, last_d;
    logic             extra_q, extra_d, mark_q, mark_d;
    logic             xfer, slot_miss, issue, issue_last;
    logic [3:0]       widx;
    logic [31:0]      pw_out;
    logic [2:0]       pw_bytes;
    logic             pw_mark;
    logic [63:0]      len64;

    assign in_ready = ~reset & ((state_q == ST_IDLE) | (state_q == ST_FILL) |
                                (state_q == ST_DRAIN));
    assign xfer     = in_valid & in_ready;
    // A continuation block that is still being built when its slot comes up.
    assign slot_miss = (gap_q == '0) & ~first_q;
    assign widx     = bp_q[5:2];
    assign bp_nxt   = bp_q + {4'b0000, in_bytes};
    assign len64    = 64'(len_q);
    // PAD reuses the merger with no data bytes to drop the marker at bp.
    assign pw_bytes = (state_q == ST_PAD) ? 3'd0 : in_bytes;
    assign pw_mark  = (state_q == ST_PAD);

    sha_pad_word u_pad_word (
        .cur_word (blk_q[widx]),
        .in_data  (in_data),
        .in_bytes (pw_bytes),
        .offset   (bp_q[1:0]),
        .mark     (pw_mark),
        .word_out (pw_out)
    );

    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        bp_d        = bp_q;
        len_d       = len_q;
        gap_d       = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        msg_d       = msg_q;
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        err_d       = 1'b0;
        first_d     = first_q;
        last_d      = last_q;
        extra_d     = extra_q;
        mark_d      = mark_q;
        issue       = 1'b0;
        issue_last  = last_q;
        issue_blk   = blk_q;

        len_blk = blk_q;
        len_blk[LEN_WORD_HI]   = len64[63:32];
        len_blk[LEN_WORD_HI+1] = len64[31:0];

        case (state_q)
            ST_IDLE, ST_FILL: begin
                if ((state_q == ST_FILL) && slot_miss) begin
                    err_d   = 1'b1;
                    blk_d   = '0;
                    bp_d    = '0;
                    len_d   = '0;
                    first_d = 1'b1;
                    state_d = (xfer && in_last) ? ST_IDLE : ST_DRAIN;
                end else if (xfer) begin
                    blk_d[widx] = pw_out;
                    bp_d        = bp_nxt;
                    len_d       = len_q + LEN_W'({in_bytes, 3'b000});
                    if (in_last) begin
                        state_d = ST_PAD;
                    end else if (bp_nxt[6]) begin
                        state_d = ST_WAIT;
                        last_d  = 1'b0;
                        extra_d = 1'b0;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_PAD: begin
                if (slot_miss) begin
                    err_d   = 1'b1;
                    blk_d   = '0;
                    bp_d    = '0;
                    len_d   = '0;
                    first_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (bp_q[6]) begin
                    // Data filled the block exactly: marker opens the extra block.
                    state_d = ST_WAIT;
                    last_d  = 1'b0;
                    extra_d = 1'b1;
                    mark_d  = 1'b1;
                end else begin
                    blk_d[widx] = pw_out;
                    if (bp_q <= 7'd55) begin
                        state_d = ST_LEN;
                    end else begin
                        // No room left for the length field.
                        state_d = ST_WAIT;
                        last_d  = 1'b0;
                        extra_d = 1'b1;
                        mark_d  = 1'b0;
                    end
                end
            end
            ST_LEN: begin
                if (gap_q == '0) begin
                    issue      = 1'b1;
                    issue_blk  = len_blk;
                    issue_last = 1'b1;
                end else begin
                    blk_d   = len_blk;
                    last_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (gap_q == '0) begin
                    issue = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (xfer && in_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            out_valid_d = 1'b1;
            out_first_d = first_q;
            out_last_d  = issue_last;
            msg_d       = issue_blk;
            gap_d       = GAP_W'(BLOCK_GAP - 1);
            first_d     = issue_last;
            blk_d       = '0;
            bp_d        = '0;
            if (issue_last) begin
                len_d   = '0;
                state_d = ST_IDLE;
            end else if (extra_q) begin
                if (mark_q) begin
                    blk_d[0] = {PAD_BYTE, 24'h000000};
                end
                extra_d = 1'b0;
                state_d = ST_LEN;
            end else begin
                state_d = ST_FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            blk_q       <= '0;
            bp_q        <= '0;
            len_q       <= '0;
            gap_q       <= '0;
            msg_q       <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            first_q     <= 1'b1;
            last_q      <= 1'b0;
            extra_q     <= 1'b0;
            mark_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            bp_q        <= bp_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            msg_q       <= msg_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            first_q     <= first_d;
            last_q      <= last_d;
            extra_q     <= extra_d;
            mark_q      <= mark_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_first    = out_first_q;
    assign out_last     = out_last_q;
    assign message      = msg_q;
    assign err_underrun = err_q;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Scoreboard bench for sha_msg_padder: a byte-level FIPS 180-4 padding
// model produces expected blocks, a monitor compares every strobe.
module tb_sha_msg_padder;

    localparam int BLOCK_GAP = 64;

    typedef logic [7:0] byteq_t[$];
    typedef struct {
        bit           is_err;
        logic [511:0] blk;
        bit           first;
        bit           last;
        bit           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_last;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         out_valid, out_first, out_last, err_underrun;
    logic [511:0] message;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           last_xfer_cyc = 0;
    int           prev_cyc = 0;
    bit           prev_ok = 0;
    exp_t         exp_q[$];
    logic [511:0] mdl_q[$];

    sha_msg_padder #(.BLOCK_GAP(BLOCK_GAP), .LEN_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_bytes     (in_bytes),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_first    (out_first),
        .out_last     (out_last),
        .message      (message),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic byteq_t str2q(input string s);
        byteq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Padding rule applied to the whole message as a byte list.
    task automatic model(input byteq_t msg);
        byteq_t       p;
        logic [63:0]  bits;
        logic [511:0] v;
        mdl_q.delete();
        p    = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int k = 0; k < 64; k++) v[511-8*k -: 8] = p[64*b+k];
            mdl_q.push_back(v);
        end
    endtask

    task automatic expect_msg(input byteq_t msg, input bit lat);
        exp_t e;
        model(msg);
        foreach (mdl_q[b]) begin
            e.is_err = 0;
            e.blk    = mdl_q[b];
            e.first  = (b == 0);
            e.last   = (b == mdl_q.size() - 1);
            e.lat    = lat;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input byteq_t msg, input bit rnd, input int stall_at,
                        input int stall_len, input int max_words);
        int          n, nw, nb, waited;
        logic [31:0] d;
        n  = msg.size();
        nw = (n == 0) ? 1 : (n + 3) / 4;
        for (int w = 0; w < nw && w < max_words; w++) begin
            nb = n - 4 * w;
            if (nb > 4) nb = 4;
            d = '0;
            for (int k = 0; k < nb; k++) d[31-8*k -: 8] = msg[4*w+k];
            if (w == stall_at) idle(stall_len);
            else if (rnd && ($urandom_range(0, 5) == 0)) idle($urandom_range(1, 2));
            in_valid = 1'b1;
            in_data  = d;
            in_bytes = 3'(nb);
            in_last  = (w == nw - 1);
            waited   = 0;
            @(negedge clk);
            while (!in_ready && waited < 300) begin
                waited++;
                @(negedge clk);
            end
            if (!in_ready) begin
                total++;
                bad++;
                $display("FAIL in_ready_timeout word=%0d got=0 want=1", w);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            if (in_last) last_xfer_cyc = cyc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: pops one expectation per strobe or underrun pulse.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_ok = 0;
        end else if (out_valid || err_underrun) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output valid=%0b err=%0b want none", out_valid, err_underrun);
            end else begin
                e = exp_q.pop_front();
                check("err_flag", err_underrun, e.is_err);
                if (!e.is_err && out_valid) begin
                    check("block", message, e.blk);
                    check("first", out_first, e.first);
                    check("last", out_last, e.last);
                    if (prev_ok) begin
                        if (!e.first) check("block_spacing", cyc - prev_cyc, BLOCK_GAP);
                        else check("first_spacing_ge_gap", (cyc - prev_cyc) >= BLOCK_GAP, 1);
                    end
                    if (e.lat) check("pad_latency_le3", (cyc - last_xfer_cyc) <= 3, 1);
                    prev_cyc = cyc;
                    prev_ok  = 1;
                end else if (e.is_err && prev_ok) begin
                    check("underrun_slot", cyc - prev_cyc, BLOCK_GAP);
                end
            end
        end
    end

    initial begin
        byteq_t m;
        exp_t   e;
        int     waited;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_bytes = '0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_first", out_first, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err", err_underrun, 0);
        check("rst_message", message, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);
        @(posedge clk);
        #1;

        m = str2q("abc");
        expect_msg(m, 1);
        send(m, 0, -1, 0, 1000);
        idle(70);

        m = str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        expect_msg(m, 0);
        send(m, 0, -1, 0, 1000);
        idle(140);

        m.delete();
        expect_msg(m, 1);
        send(m, 0, -1, 0, 1000);
        idle(70);

        m.delete();
        for (int i = 0; i < 55; i++) m.push_back(8'(i * 7 + 3));
        expect_msg(m, 1);
        send(m, 0, -1, 0, 1000);
        idle(70);

        m.delete();
        for (int i = 0; i < 64; i++) m.push_back(8'(i * 13 + 1));
        expect_msg(m, 0);
        send(m, 0, -1, 0, 1000);
        idle(140);

        // 80-byte message whose source stalls 70 cycles after word 16.
        m.delete();
        for (int i = 0; i < 80; i++) m.push_back(8'(i + 5));
        model(m);
        e.is_err = 0; e.blk = mdl_q[0]; e.first = 1; e.last = 0; e.lat = 0;
        exp_q.push_back(e);
        e.is_err = 1; e.blk = '0; e.first = 0; e.last = 0; e.lat = 0;
        exp_q.push_back(e);
        send(m, 0, 16, 70, 1000);
        idle(10);
        m = str2q("abc");
        expect_msg(m, 1);
        send(m, 0, -1, 0, 1000);
        idle(70);

        // Reset in the middle of a multi-block message.
        m.delete();
        for (int i = 0; i < 120; i++) m.push_back(8'($urandom));
        send(m, 0, -1, 0, 8);
        reset = 1'b1;
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
        m = str2q("abc");
        expect_msg(m, 1);
        send(m, 0, -1, 0, 1000);
        idle(70);

        repeat (25) begin
            m.delete();
            repeat ($urandom_range(0, 150)) m.push_back(8'($urandom));
            expect_msg(m, 0);
            send(m, 1, -1, 0, 1000);
            idle($urandom_range(0, 3));
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
